pipe_hazard_ctrl: RTL and testbench

Stall/flush controller for the five-stage MIPS pipeline. It drives the enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazards: load-use, control redirects resolved in MEM, and multi-cycle data-memory accesses. A bounded wait timer locks the pipeline on a hung memory; stall and flush counters support performance debug.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 14 +
 rtl/pipe_hazard_ctrl_sat_counter.sv | 28 ++
 rtl/pipe_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller.
//   hazardState_e : controller state encoding (RUN, MEM_WAIT, ERROR)
//   REG_IDX_W     : width of an architectural register index
package pipe_hazard_ctrl_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hazardState_e;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// hazard_sat_counter: event counter that counts up by one when inc is high
// and sticks at all-ones instead of wrapping.
//   clock : rising-edge clock
//   reset : synchronous, active-high; clears the count
//   inc   : count this cycle
//   count : current count value
module hazard_sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] countReg;

  always_ff @(posedge clock) begin
    if (reset) begin
      countReg <= '0;
    end else if (inc && (countReg != {W{1'b1}})) begin
      countReg <= countReg + 1'b1;
    end
  end

  assign count = countReg;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for the five-stage pipeline.
// Resolves memory wait stalls, MEM-stage redirects and load-use hazards,
// with a bounded wait timer that locks the pipeline on a hung memory.
//   clock, reset                     : clock and synchronous active-high reset
//   id_rs, id_rt, id_uses_rt         : sources of the instruction in IF/ID
//   ex_memread, ex_valid, ex_rt      : load held in ID/EX
//   mem_valid, mem_redirect,
//   mem_access, dmem_ack             : EX/MEM entry and data-memory handshake
//   pc_enable, pc_redirect           : PC update enable and target select
//   *_enable, *_flush                : pipeline register load enables / bubbles
//   err                              : memory timeout, sticky until reset
//   stall_count, flush_count         : saturating performance counters
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic                 id_uses_rt,
  input  logic                 ex_memread,
  input  logic                 ex_valid,
  input  logic [REG_IDX_W-1:0] ex_rt,
  input  logic                 mem_valid,
  input  logic                 mem_redirect,
  input  logic                 mem_access,
  input  logic                 dmem_ack,
  output logic                 pc_enable,
  output logic                 pc_redirect,
  output logic                 ifid_enable,
  output logic                 idex_enable,
  output logic                 exmem_enable,
  output logic                 memwb_enable,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 exmem_flush,
  output logic                 memwb_flush,
  output logic                 err,
  output logic [CNT_W-1:0]     stall_count,
  output logic [CNT_W-1:0]     flush_count
);

  localparam int TIMER_W = $clog2(MEM_TIMEOUT + 1);
  // Timer value seen during the last allowed wait cycle; a stall still
  // pending at that point sends the controller to ERROR.
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(MEM_TIMEOUT - 1);

  hazardState_e        stateReg, stateNext;
  logic [TIMER_W-1:0]  waitTimerReg, waitTimerNext;
  logic                memStall, redirectHit, loadUseHit;
  logic                flushEvent;

  assign memStall    = mem_valid & mem_access & ~dmem_ack;
  assign redirectHit = mem_valid & mem_redirect;
  // r0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign loadUseHit  = ex_valid & ex_memread & (ex_rt != '0) &
                       ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  always_ff @(posedge clock) begin
    if (reset) begin
      stateReg     <= RUN;
      waitTimerReg <= '0;
    end else begin
      stateReg     <= stateNext;
      waitTimerReg <= waitTimerNext;
    end
  end

  always_comb begin
    pc_enable     = 1'b1;
    ifid_enable   = 1'b1;
    idex_enable   = 1'b1;
    exmem_enable  = 1'b1;
    memwb_enable  = 1'b1;
    pc_redirect   = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    memwb_flush   = 1'b0;
    flushEvent    = 1'b0;
    stateNext     = stateReg;

    if (reset) begin
      pc_enable    = 1'b0;
      ifid_enable  = 1'b0;
      idex_enable  = 1'b0;
      exmem_enable = 1'b0;
      memwb_enable = 1'b0;
      stateNext    = RUN;
    end else begin
      case (stateReg)
        ERROR: begin
          pc_enable    = 1'b0;
          ifid_enable  = 1'b0;
          idex_enable  = 1'b0;
          exmem_enable = 1'b0;
          memwb_enable = 1'b0;
          stateNext    = ERROR;
        end
        default: begin
          if (memStall) begin
            // Freeze everything up to EX/MEM; MEM/WB takes a bubble.
            pc_enable    = 1'b0;
            ifid_enable  = 1'b0;
            idex_enable  = 1'b0;
            exmem_enable = 1'b0;
            memwb_flush  = 1'b1;
            if ((stateReg == MEM_WAIT) && (waitTimerReg == TIMEOUT_LAST)) begin
              stateNext = ERROR;
            end else begin
              stateNext = MEM_WAIT;
            end
          end else begin
            // Ack (or no pending access) behaves as a normal RUN cycle, so a
            // redirect or load-use hazard waiting behind the access is honoured.
            stateNext = RUN;
            if (redirectHit) begin
              pc_redirect = 1'b1;
              ifid_flush  = 1'b1;
              idex_flush  = 1'b1;
              exmem_flush = 1'b1;
              flushEvent  = 1'b1;
            end else if (loadUseHit) begin
              pc_enable   = 1'b0;
              ifid_enable = 1'b0;
              idex_flush  = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Counts consecutive cycles spent in MEM_WAIT; zero on entry and outside it.
  always_comb begin
    waitTimerNext = '0;
    if ((stateReg == MEM_WAIT) && (stateNext == MEM_WAIT)) begin
      waitTimerNext = waitTimerReg + 1'b1;
    end
  end

  assign err = (stateReg == ERROR);

  hazard_sat_counter #(.W(CNT_W)) stallCounter (
    .clock (clock),
    .reset (reset),
    .inc   (~reset & ~pc_enable),
    .count (stall_count)
  );

  hazard_sat_counter #(.W(CNT_W)) flushCounter (
    .clock (clock),
    .reset (reset),
    .inc   (flushEvent),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic [4:0]       id_rs, id_rt, ex_rt;
  logic             id_uses_rt, ex_memread, ex_valid;
  logic             mem_valid, mem_redirect, mem_access, dmem_ack;
  logic             pc_enable, pc_redirect;
  logic             ifid_enable, idex_enable, exmem_enable, memwb_enable;
  logic             ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic             err;
  logic [CNT_W-1:0] stall_count, flush_count;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_memread   (ex_memread),
    .ex_valid     (ex_valid),
    .ex_rt        (ex_rt),
    .mem_valid    (mem_valid),
    .mem_redirect (mem_redirect),
    .mem_access   (mem_access),
    .dmem_ack     (dmem_ack),
    .pc_enable    (pc_enable),
    .pc_redirect  (pc_redirect),
    .ifid_enable  (ifid_enable),
    .idex_enable  (idex_enable),
    .exmem_enable (exmem_enable),
    .memwb_enable (memwb_enable),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .memwb_flush  (memwb_flush),
    .err          (err),
    .stall_count  (stall_count),
    .flush_count  (flush_count)
  );

  always #5 clock = ~clock;

  // en = {pc, ifid, idex, exmem, memwb}; fl = {ifid, idex, exmem, memwb}
  // errE/stallE/flushE of -1 mean "not checked on this transaction".
  typedef struct {
    string      tag;
    logic [4:0] en;
    logic [3:0] fl;
    logic       redir;
    int         errE;
    int         stallE;
    int         flushE;
  } exp_t;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  localparam logic [4:0] EN_ALL  = 5'b11111;
  localparam logic [4:0] EN_NONE = 5'b00000;
  localparam logic [4:0] EN_LU   = 5'b00111;
  localparam logic [4:0] EN_MEM  = 5'b00001;
  localparam logic [3:0] FL_NONE = 4'b0000;
  localparam logic [3:0] FL_LU   = 4'b0100;
  localparam logic [3:0] FL_RED  = 4'b1110;
  localparam logic [3:0] FL_MEM  = 4'b0001;

  // Monitor: the controller's outputs are valid every cycle; compare at the
  // falling edge whenever a stimulus transaction is outstanding.
  always @(negedge clock) begin
    exp_t       e;
    logic [4:0] actEn;
    logic [3:0] actFl;
    logic       bad;
    if (expQ.size() != 0) begin
      e     = expQ.pop_front();
      actEn = {pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable};
      actFl = {ifid_flush, idex_flush, exmem_flush, memwb_flush};
      bad   = (actEn !== e.en) || (actFl !== e.fl) || (pc_redirect !== e.redir);
      if ((e.errE >= 0) && (err !== e.errE[0])) bad = 1'b1;
      if ((e.stallE >= 0) && (stall_count !== CNT_W'(e.stallE))) bad = 1'b1;
      if ((e.flushE >= 0) && (flush_count !== CNT_W'(e.flushE))) bad = 1'b1;
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL %s: got en=%b fl=%b redir=%b err=%b stall=%0d flush=%0d, want en=%b fl=%b redir=%b err=%0d stall=%0d flush=%0d",
                 e.tag, actEn, actFl, pc_redirect, err, stall_count, flush_count,
                 e.en, e.fl, e.redir, e.errE, e.stallE, e.flushE);
      end else begin
        $display("txn %s ok: en=%b fl=%b redir=%b err=%b stall=%0d flush=%0d",
                 e.tag, actEn, actFl, pc_redirect, err, stall_count, flush_count);
      end
    end
  end

  // One cycle of stimulus; ld drives both ex_memread and ex_valid.
  task automatic vec(input string tag, input logic rst,
                     input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                     input logic ld, input logic [4:0] exRt,
                     input logic mv, input logic redirect, input logic access, input logic ack,
                     input logic [4:0] en, input logic [3:0] fl, input logic redir,
                     input int errE, input int stallE, input int flushE);
    exp_t e;
    @(posedge clock);
    #1;
    reset        = rst;
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rt   = usesRt;
    ex_memread   = ld;
    ex_valid     = ld;
    ex_rt        = exRt;
    mem_valid    = mv;
    mem_redirect = redirect;
    mem_access   = access;
    dmem_ack     = ack;
    e.tag = tag; e.en = en; e.fl = fl; e.redir = redir;
    e.errE = errE; e.stallE = stallE; e.flushE = flushE;
    expQ.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
    ex_memread = 1'b0; ex_valid = 1'b0; ex_rt = '0;
    mem_valid = 1'b0; mem_redirect = 1'b0; mem_access = 1'b0; dmem_ack = 1'b0;
    repeat (2) @(posedge clock);

    //   tag          rst rs rt uRt ld exRt mv red acc ack  en       fl       rd err stall flush
    vec("reset_hold", 1, 5, 0, 0,  1, 5,   1, 1,  1,  0,   EN_NONE, FL_NONE, 0, 0,  0,  0);
    vec("idle",       0, 0, 0, 0,  0, 0,   0, 0,  0,  0,   EN_ALL,  FL_NONE, 0, 0,  0,  0);
    vec("loaduse_rs", 0, 5, 0, 0,  1, 5,   0, 0,  0,  0,   EN_LU,   FL_LU,   0, 0,  0,  0);
    vec("lu_clear",   0, 5, 0, 0,  0, 0,   0, 0,  0,  0,   EN_ALL,  FL_NONE, 0, 0,  1,  0);
    vec("reg0",       0, 0, 0, 0,  1, 0,   0, 0,  0,  0,   EN_ALL,  FL_NONE, 0, 0,  1,  0);
    vec("rt_unused",  0, 3, 5, 0,  1, 5,   0, 0,  0,  0,   EN_ALL,  FL_NONE, 0, 0,  1,  0);
    vec("loaduse_rt", 0, 3, 5, 1,  1, 5,   0, 0,  0,  0,   EN_LU,   FL_LU,   0, 0,  1,  0);
    vec("redir_lu",   0, 5, 0, 0,  1, 5,   1, 1,  0,  0,   EN_ALL,  FL_RED,  1, 0,  2,  0);
    vec("redir_inval",0, 0, 0, 0,  0, 0,   0, 1,  0,  0,   EN_ALL,  FL_NONE, 0, 0,  2,  1);
    vec("mwait_c1",   0, 0, 0, 0,  0, 0,   1, 0,  1,  0,   EN_MEM,  FL_MEM,  0, 0,  2,  1);
    vec("mwait_c2",   0, 0, 0, 0,  0, 0,   1, 0,  1,  0,   EN_MEM,  FL_MEM,  0, 0,  3,  1);
    vec("mwait_c3",   0, 0, 0, 0,  0, 0,   1, 0,  1,  0,   EN_MEM,  FL_MEM,  0, 0,  4,  1);
    vec("mwait_ack",  0, 0, 0, 0,  0, 0,   1, 0,  1,  1,   EN_ALL,  FL_NONE, 0, 0,  5,  1);
    vec("ack_noacc",  0, 0, 0, 0,  0, 0,   0, 0,  0,  1,   EN_ALL,  FL_NONE, 0, 0,  5,  1);
    vec("tmo_c1",     0, 0, 0, 0,  0, 0,   1, 0,  1,  0,   EN_MEM,  FL_MEM,  0, 0,  5,  1);
    vec("tmo_c2",     0, 0, 0, 0,  0, 0,   1, 0,  1,  0,   EN_MEM,  FL_MEM,  0, 0,  6,  1);
    vec("tmo_c3",     0, 0, 0, 0,  0, 0,   1, 0,  1,  0,   EN_MEM,  FL_MEM,  0, 0,  7,  1);
    vec("tmo_c4",     0, 0, 0, 0,  0, 0,   1, 0,  1,  0,   EN_MEM,  FL_MEM,  0, 0,  8,  1);
    vec("tmo_c5",     0, 0, 0, 0,  0, 0,   1, 0,  1,  0,   EN_MEM,  FL_MEM,  0, 0,  9,  1);
    vec("error",      0, 0, 0, 0,  0, 0,   1, 0,  1,  0,   EN_NONE, FL_NONE, 0, 1, 10,  1);
    vec("err_lateack",0, 5, 0, 0,  1, 5,   1, 1,  1,  1,   EN_NONE, FL_NONE, 0, 1, 11,  1);
    vec("err_reset",  1, 0, 0, 0,  0, 0,   1, 0,  1,  0,   EN_NONE, FL_NONE, 0, -1, 12, 1);
    vec("post_reset", 0, 0, 0, 0,  0, 0,   0, 0,  0,  0,   EN_ALL,  FL_NONE, 0, 0,  0,  0);
    vec("mw2_c1",     0, 0, 0, 0,  0, 0,   1, 0,  1,  0,   EN_MEM,  FL_MEM,  0, 0,  0,  0);
    vec("mw2_c2",     0, 0, 0, 0,  0, 0,   1, 0,  1,  0,   EN_MEM,  FL_MEM,  0, 0,  1,  0);
    vec("mw2_reset",  1, 0, 0, 0,  0, 0,   1, 0,  1,  0,   EN_NONE, FL_NONE, 0, 0, -1, -1);
    vec("mw2_after",  0, 0, 0, 0,  0, 0,   0, 0,  0,  0,   EN_ALL,  FL_NONE, 0, 0,  0,  0);

    for (int i = 0; i < 20; i++) begin
      vec($sformatf("sat%0d", i), 0, 5, 0, 0, 1, 5, 0, 0, 0, 0,
          EN_LU, FL_LU, 0, 0, (i > 15) ? 15 : i, -1);
    end
    vec("sat_hold",   0, 0, 0, 0,  0, 0,   0, 0,  0,  0,   EN_ALL,  FL_NONE, 0, 0, 15,  0);

    // Let the monitor drain; anything left over after a bounded wait is a miss.
    for (int i = 0; i < 4 && expQ.size() != 0; i++) @(negedge clock);
    #1;
    if (expQ.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d unchecked transactions, want 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
